// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The requester drives start/a/b and observes busy/done/sum/cout.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders plus
// an OR) is stepped over a WIDTH-bit operand pair, LSB first, one bit per
// clock. Result registers change only when an operation completes.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ha0_sum, ha0_cout;
  logic             ha1_sum, ha1_cout;
  logic             carry_fa;
  logic [WIDTH-1:0] a_shift, b_shift, s_shift;

  // Counter increment as a ripple of half-adder terms, keeping the block free
  // of any behavioural adder.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] x);
    logic [CW-1:0] r;
    logic          c;
    c = 1'b1;
    for (int i = 0; i < CW; i++) begin
      r[i] = x[i] ^ c;
      c    = c & x[i];
    end
    return r;
  endfunction

  // The single full-adder slice: HA0 adds the operand bits, HA1 folds in carry.
  half_adder u_ha0 (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .sum  (ha0_sum),
    .cout (ha0_cout)
  );

  half_adder u_ha1 (
    .a    (ha0_sum),
    .b    (carry_q),
    .sum  (ha1_sum),
    .cout (ha1_cout)
  );

  assign carry_fa = ha0_cout | ha1_cout;

  // Shifted views of the datapath registers; the new sum bit enters at the MSB.
  always_comb begin
    a_shift          = a_sh_q >> 1'b1;
    b_shift          = b_sh_q >> 1'b1;
    s_shift          = s_sh_q >> 1'b1;
    s_shift[WIDTH-1] = ha1_sum;
  end

  // Next-state and next-datapath decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          s_sh_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_shift;
        b_sh_d  = b_shift;
        s_sh_d  = s_shift;
        carry_d = carry_fa;
        cnt_d   = cnt_inc(cnt_q);
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the accumulator including this bit.
          state_d = DONE;
          sum_d   = s_shift;
          cout_d  = carry_fa;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state's decode.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random operand pairs
// on a WIDTH=8 instance and a WIDTH=1 instance, compared against plain
// arithmetic and a cycle-count timing model.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst8;
  logic rst1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_sum8  = 8'h00;
  logic       exp_cout8 = 1'b0;
  logic       exp_sum1  = 1'b0;
  logic       exp_cout1 = 1'b0;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: full-precision sum, top bit is the carry out.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // One WIDTH=8 operation from IDLE; optional re-pulses of start during RUN
  // cycle 3 and during the DONE cycle must be ignored.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit repulse);
    logic [8:0] r;
    r = ref_add8(x, y);
    bus8.start = 1'b1;
    bus8.a     = x;
    bus8.b     = y;
    @(posedge clk); @(negedge clk);
    chk("w8_accept_busy", {31'd0, bus8.busy}, 32'd1);
    chk("w8_accept_done", {31'd0, bus8.done}, 32'd0);
    chk("w8_accept_sum_hold", {24'd0, bus8.sum}, {24'd0, exp_sum8});
    for (int i = 1; i <= 8; i++) begin
      if (repulse && i == 3) begin
        bus8.start = 1'b1;
        bus8.a     = 8'h11;
        bus8.b     = 8'h22;
      end else begin
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
      end
      @(posedge clk); @(negedge clk);
      if (i < 8) begin
        chk("w8_run_busy", {31'd0, bus8.busy}, 32'd1);
        chk("w8_run_done", {31'd0, bus8.done}, 32'd0);
        chk("w8_run_sum_hold", {24'd0, bus8.sum}, {24'd0, exp_sum8});
        chk("w8_run_cout_hold", {31'd0, bus8.cout}, {31'd0, exp_cout8});
      end else begin
        chk("w8_done_busy", {31'd0, bus8.busy}, 32'd0);
        chk("w8_done_pulse", {31'd0, bus8.done}, 32'd1);
        chk("w8_sum", {24'd0, bus8.sum}, {24'd0, r[7:0]});
        chk("w8_cout", {31'd0, bus8.cout}, {31'd0, r[8]});
      end
    end
    exp_sum8  = r[7:0];
    exp_cout8 = r[8];
    bus8.start = repulse;
    bus8.a     = 8'h11;
    bus8.b     = 8'h22;
    @(posedge clk); @(negedge clk);
    chk("w8_idle_done", {31'd0, bus8.done}, 32'd0);
    chk("w8_idle_busy", {31'd0, bus8.busy}, 32'd0);
    chk("w8_idle_sum", {24'd0, bus8.sum}, {24'd0, exp_sum8});
    bus8.start = 1'b0;
    if (repulse) begin
      @(posedge clk); @(negedge clk);
      chk("w8_repulse_not_taken_busy", {31'd0, bus8.busy}, 32'd0);
      chk("w8_repulse_not_taken_done", {31'd0, bus8.done}, 32'd0);
      chk("w8_repulse_sum", {24'd0, bus8.sum}, {24'd0, exp_sum8});
    end
  endtask

  // One WIDTH=1 operation: RUN lasts a single cycle.
  task automatic op1(input logic x, input logic y);
    logic [1:0] r;
    r = {1'b0, x} + {1'b0, y};
    bus1.start = 1'b1;
    bus1.a     = x;
    bus1.b     = y;
    @(posedge clk); @(negedge clk);
    chk("w1_accept_busy", {31'd0, bus1.busy}, 32'd1);
    chk("w1_accept_done", {31'd0, bus1.done}, 32'd0);
    chk("w1_accept_sum_hold", {31'd0, bus1.sum}, {31'd0, exp_sum1});
    bus1.start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("w1_done_pulse", {31'd0, bus1.done}, 32'd1);
    chk("w1_done_busy", {31'd0, bus1.busy}, 32'd0);
    chk("w1_sum", {31'd0, bus1.sum}, {31'd0, r[0]});
    chk("w1_cout", {31'd0, bus1.cout}, {31'd0, r[1]});
    exp_sum1  = r[0];
    exp_cout1 = r[1];
    @(posedge clk); @(negedge clk);
    chk("w1_idle_done", {31'd0, bus1.done}, 32'd0);
    chk("w1_idle_busy", {31'd0, bus1.busy}, 32'd0);
  endtask

  initial begin
    logic [8:0] r;
    int         ph;

    rst8 = 1'b1;
    rst1 = 1'b1;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy8", {31'd0, bus8.busy}, 32'd0);
    chk("rst_done8", {31'd0, bus8.done}, 32'd0);
    chk("rst_sum8", {24'd0, bus8.sum}, 32'd0);
    chk("rst_cout8", {31'd0, bus8.cout}, 32'd0);
    chk("rst_busy1", {31'd0, bus1.busy}, 32'd0);
    chk("rst_done1", {31'd0, bus1.done}, 32'd0);
    rst8 = 1'b0;
    rst1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_no_start_busy", {31'd0, bus8.busy}, 32'd0);

    // Directed operand pairs.
    op8(8'h35, 8'h4A, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'hC3, 8'h5A, 1'b1);

    // Asynchronous reset in the middle of bit 4.
    bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h66;
    @(posedge clk); @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
    chk("abort_done", {31'd0, bus8.done}, 32'd0);
    chk("abort_sum", {24'd0, bus8.sum}, 32'd0);
    chk("abort_cout", {31'd0, bus8.cout}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    exp_sum8  = 8'h00;
    exp_cout8 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_no_done", {31'd0, bus8.done}, 32'd0);
      chk("abort_no_busy", {31'd0, bus8.busy}, 32'd0);
    end
    op8(8'h0F, 8'h01, 1'b0);

    // start held high: one operation every WIDTH+2 cycles.
    r = ref_add8(8'h80, 8'h80);
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); @(negedge clk);
      ph = c % 10;
      chk("held_busy", {31'd0, bus8.busy}, (ph < 8) ? 32'd1 : 32'd0);
      chk("held_done", {31'd0, bus8.done}, (ph == 8) ? 32'd1 : 32'd0);
      if (ph == 8) begin
        chk("held_sum", {24'd0, bus8.sum}, {24'd0, r[7:0]});
        chk("held_cout", {31'd0, bus8.cout}, {31'd0, r[8]});
      end
    end
    bus8.start = 1'b0;
    exp_sum8  = r[7:0];
    exp_cout8 = r[8];
    @(posedge clk); @(negedge clk);
    chk("held_release_busy", {31'd0, bus8.busy}, 32'd0);

    // Random operand pairs, some with ignored start re-pulses.
    for (int n = 0; n < 16; n++) begin
      op8(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    // WIDTH=1 instance.
    op1(1'b1, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
